// File: rtl/dna_port_emu.sv
// Emulation of a serial device-identifier port: a loadable 57-bit ID register,
// a shift-out register with a saturating shift counter, and a sticky protocol-error flag.
module dna_port_emu #(
  parameter int                   DNA_WIDTH = 57,
  parameter logic [DNA_WIDTH-1:0] DNA_INIT  = 57'h1A5A5A5A5A5A5A5
) (
  input  logic                 ap_clk,
  input  logic                 areset,
  input  logic                 dna_read,
  input  logic                 dna_shift,
  input  logic                 dna_din,
  output logic                 dna_dout,
  input  logic                 prog_valid,
  output logic                 prog_ready,
  input  logic [DNA_WIDTH-1:0] prog_value,
  input  logic                 err_clr,
  output logic [6:0]           shift_cnt,
  output logic                 exhausted,
  output logic                 proto_err,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOADED    = 2'd1,
    SHIFTING  = 2'd2,
    EXHAUSTED = 2'd3
  } state_t;

  localparam logic [6:0] CNT_MAX = 7'(DNA_WIDTH);

  state_t               state, state_nxt;
  logic [DNA_WIDTH-1:0] id_reg, id_nxt;
  logic [DNA_WIDTH-1:0] sr, sr_nxt;
  logic [6:0]           cnt, cnt_nxt;
  logic                 err, err_nxt;
  logic                 viol;

  function automatic logic [6:0] sat_inc(input logic [6:0] c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 7'd1;
  endfunction

  assign prog_ready = !areset && (state != SHIFTING) && !dna_read;
  assign dna_dout   = sr[0];
  assign shift_cnt  = cnt;
  assign exhausted  = (cnt == CNT_MAX);
  assign proto_err  = err;
  assign state_o    = state;

  // Simultaneous read+shift, shifting with nothing loaded, and reprogramming mid-transfer
  assign viol = (dna_read && dna_shift) ||
                (dna_shift && !dna_read && (state == IDLE)) ||
                (prog_valid && dna_shift && (state == SHIFTING));

  always_comb begin
    state_nxt = state;
    id_nxt    = id_reg;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    err_nxt   = err;

    if (dna_read) begin
      sr_nxt    = id_reg;
      cnt_nxt   = 7'd0;
      state_nxt = LOADED;
    end else if (dna_shift) begin
      sr_nxt = {dna_din, sr[DNA_WIDTH-1:1]};
      // Nothing is loaded in IDLE, so the count of shifts since a load stays at zero
      if (state != IDLE) begin
        cnt_nxt   = sat_inc(cnt);
        state_nxt = (sat_inc(cnt) == CNT_MAX) ? EXHAUSTED : SHIFTING;
      end
    end

    if (prog_valid && prog_ready)
      id_nxt = prog_value;

    if (err_clr)
      err_nxt = 1'b0;
    if (viol)
      err_nxt = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state  <= IDLE;
      id_reg <= DNA_INIT;
      sr     <= '0;
      cnt    <= 7'd0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      id_reg <= id_nxt;
      sr     <= sr_nxt;
      cnt    <= cnt_nxt;
      err    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_dna_port_emu.sv
// Bench for dna_port_emu: behavioural model plus per-cycle compare, directed scenarios
// with literal expectations, then a randomized phase.
module tb_dna_port_emu;

  localparam logic [56:0] INIT = 57'h1A5A5A5A5A5A5A5;

  logic        ap_clk = 1'b0;
  logic        areset = 1'b1;
  logic        dna_read = 1'b0, dna_shift = 1'b0, dna_din = 1'b0;
  logic        dna_dout;
  logic        prog_valid = 1'b0, prog_ready;
  logic [56:0] prog_value = '0;
  logic        err_clr = 1'b0;
  logic [6:0]  shift_cnt;
  logic        exhausted, proto_err;
  logic [1:0]  state_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  dna_port_emu dut (
    .ap_clk(ap_clk), .areset(areset), .dna_read(dna_read), .dna_shift(dna_shift),
    .dna_din(dna_din), .dna_dout(dna_dout), .prog_valid(prog_valid),
    .prog_ready(prog_ready), .prog_value(prog_value), .err_clr(err_clr),
    .shift_cnt(shift_cnt), .exhausted(exhausted), .proto_err(proto_err),
    .state_o(state_o)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: the identifier as a number, shift count as an integer,
  // state derived from "has been loaded" and the count.
  logic [56:0] m_id = INIT;
  logic [56:0] m_sr = '0;
  int          m_cnt = 0;
  bit          m_loaded = 1'b0;
  bit          m_err = 1'b0;

  function automatic int m_state(input bit loaded, input int c);
    if (!loaded) return 0;
    if (c == 0)  return 1;
    if (c < 57)  return 2;
    return 3;
  endfunction

  always @(posedge ap_clk) begin : model
    int st;
    bit viol, acc;
    if (areset) begin
      m_id = INIT; m_sr = '0; m_cnt = 0; m_loaded = 1'b0; m_err = 1'b0;
    end else begin
      st   = m_state(m_loaded, m_cnt);
      viol = (dna_read && dna_shift) || (dna_shift && !dna_read && st == 0) ||
             (prog_valid && dna_shift && st == 2);
      acc  = prog_valid && (st != 2) && !dna_read;
      if (dna_read) begin
        m_sr = m_id; m_cnt = 0; m_loaded = 1'b1;
      end else if (dna_shift) begin
        m_sr = (m_sr >> 1) | (57'(dna_din) << 56);
        if (m_loaded && m_cnt < 57) m_cnt = m_cnt + 1;
      end
      if (acc) m_id = prog_value;
      if (err_clr) m_err = 1'b0;
      if (viol) m_err = 1'b1;
    end
  end

  always @(negedge ap_clk) begin
    if (chk_en) begin
      chk("dout",      64'(dna_dout),   64'(m_sr[0]));
      chk("shift_cnt", 64'(shift_cnt),  64'(m_cnt));
      chk("exhausted", 64'(exhausted),  64'(m_cnt == 57));
      chk("proto_err", 64'(proto_err),  64'(m_err));
      chk("state",     64'(state_o),    64'(m_state(m_loaded, m_cnt)));
      chk("prog_ready", 64'(prog_ready),
          64'(!areset && m_state(m_loaded, m_cnt) != 2 && !dna_read));
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_read();
    dna_read = 1'b1; tick(); dna_read = 1'b0;
  endtask

  initial begin
    logic [56:0] v;
    logic [7:0]  b;

    // Reset release, then read out the default identifier LSB first
    areset = 1'b1; tick(); chk_en = 1'b1; tick();
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_ready", 64'(prog_ready), 64'd0);
    areset = 1'b0;
    #1 chk("ready_after_rst", 64'(prog_ready), 64'd1);
    do_read();
    dna_din = 1'b0;
    for (int i = 0; i < 57; i++) begin
      v[i] = dna_dout; dna_shift = 1'b1; tick();
    end
    dna_shift = 1'b0;
    chk("readout_init", 64'(v), 64'(INIT));
    chk("readout_exh", 64'(exhausted), 64'd1);
    chk("readout_cnt", 64'(shift_cnt), 64'd57);
    chk("readout_err", 64'(proto_err), 64'd0);

    // Program 0xFF while LOADED, read it back 8 bits
    do_read();
    prog_valid = 1'b1; prog_value = 57'h0FF; tick(); prog_valid = 1'b0;
    do_read();
    for (int i = 0; i < 8; i++) begin
      chk("prog_bit", 64'(dna_dout), 64'd1);
      dna_shift = 1'b1; tick();
    end
    dna_shift = 1'b0;
    chk("prog_bit8", 64'(dna_dout), 64'd0);
    chk("prog_cnt", 64'(shift_cnt), 64'd8);
    chk("prog_state", 64'(state_o), 64'd2);

    // Overshift with din=1
    do_read();
    dna_din = 1'b1; dna_shift = 1'b1;
    for (int i = 0; i < 57; i++) tick();
    for (int i = 0; i < 57; i++) begin
      chk("overshift_dout", 64'(dna_dout), 64'd1);
      tick();
    end
    dna_shift = 1'b0; dna_din = 1'b0;
    chk("overshift_cnt", 64'(shift_cnt), 64'd57);
    chk("overshift_state", 64'(state_o), 64'd3);
    chk("overshift_err", 64'(proto_err), 64'd0);

    // Read and shift together, then clear
    dna_read = 1'b1; dna_shift = 1'b1; tick(); dna_read = 1'b0; dna_shift = 1'b0;
    chk("rs_cnt", 64'(shift_cnt), 64'd0);
    chk("rs_state", 64'(state_o), 64'd1);
    chk("rs_err", 64'(proto_err), 64'd1);
    chk("rs_dout", 64'(dna_dout), 64'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("clr_err", 64'(proto_err), 64'd0);

    // Shift in IDLE, then re-read mid-transfer
    areset = 1'b1; tick(); areset = 1'b0;
    dna_shift = 1'b1; tick(); dna_shift = 1'b0;
    chk("idle_err", 64'(proto_err), 64'd1);
    chk("idle_state", 64'(state_o), 64'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    do_read();
    dna_shift = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    dna_shift = 1'b0;
    chk("mid_cnt30", 64'(shift_cnt), 64'd30);
    do_read();
    chk("reread_cnt", 64'(shift_cnt), 64'd0);
    chk("reread_state", 64'(state_o), 64'd1);
    chk("reread_dout", 64'(dna_dout), 64'(INIT[0]));

    // Reset mid-shift after programming restores the default identifier
    prog_valid = 1'b1; prog_value = 57'h123456789ABCDEF; tick(); prog_valid = 1'b0;
    do_read();
    dna_shift = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    dna_shift = 1'b0;
    areset = 1'b1; tick();
    chk("rst_mid_dout", 64'(dna_dout), 64'd0);
    chk("rst_mid_cnt", 64'(shift_cnt), 64'd0);
    chk("rst_mid_state", 64'(state_o), 64'd0);
    areset = 1'b0;
    do_read();
    for (int i = 0; i < 8; i++) begin
      b[i] = dna_dout; dna_shift = 1'b1; tick();
    end
    dna_shift = 1'b0;
    chk("rst_id_low", 64'(b), 64'hA5);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      areset     = ($urandom_range(0, 99) == 0);
      dna_read   = ($urandom_range(0, 9) == 0);
      dna_shift  = ($urandom_range(0, 2) != 0);
      dna_din    = 1'($urandom);
      prog_valid = ($urandom_range(0, 7) == 0);
      prog_value = {25'($urandom), 32'($urandom)};
      err_clr    = ($urandom_range(0, 15) == 0);
      tick();
    end
    areset = 1'b0; dna_read = 1'b0; dna_shift = 1'b0; prog_valid = 1'b0; err_clr = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
